// File: rtl/fft32_pkg.sv
// Shared types, constants, twiddle ROM and helpers for the 32-point FFT sequencer.
package fft32_pkg;

    localparam int unsigned N_PTS = 32;
    localparam int unsigned LOG2N = 5;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // W32^k scaled by 1023: {round(1023*cos), round(-1023*sin)}
    localparam logic [DW-1:0] TW_ROM [16] = '{
        32'h03FF_0000, 32'h03EB_FF38, 32'h03B1_FE79, 32'h0353_FDC8,
        32'h02D3_FD2D, 32'h0238_FCAD, 32'h0187_FC4F, 32'h00C8_FC15,
        32'h0000_FC01, 32'hFF38_FC15, 32'hFE79_FC4F, 32'hFDC8_FCAD,
        32'hFD2D_FD2D, 32'hFCAD_FDC8, 32'hFC4F_FE79, 32'hFC15_FF38
    };

    // Reverse the five address bits
    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Halve both components, rounding toward -inf
    function automatic cplx_t half_scale(input cplx_t x);
        cplx_t r;
        r.re = x.re >>> 1;
        r.im = x.im >>> 1;
        return r;
    endfunction

endpackage

// File: rtl/fft32_sequencer_if.sv
// Sample/bin streams and butterfly datapath connections of the FFT sequencer.
interface fft32_sequencer_if;
    import fft32_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cplx_t in_data;
    logic  out_valid;
    logic  out_ready;
    cplx_t out_data;
    logic  out_last;
    cplx_t bf_a_t;
    cplx_t bf_b_t;
    cplx_t bf_w;
    cplx_t bf_a_f;
    cplx_t bf_b_f;

    modport slave (
        input  in_valid, in_data, out_ready, bf_a_f, bf_b_f,
        output in_ready, out_valid, out_data, out_last, bf_a_t, bf_b_t, bf_w
    );

    modport master (
        output in_valid, in_data, out_ready, bf_a_f, bf_b_f,
        input  in_ready, out_valid, out_data, out_last, bf_a_t, bf_b_t, bf_w
    );

endinterface

// File: rtl/fft32_addr_gen.sv
// In-place radix-2 DIT addressing: butterfly operand indices and twiddle index.
module fft32_addr_gen (
    input  logic [2:0] s,
    input  logic [3:0] b,
    output logic [4:0] ia,
    output logic [4:0] ib,
    output logic [3:0] k
);

    logic [4:0] half;
    logic [4:0] pos;

    // Butterfly b of stage s pairs ia with ia+2^s; twiddle step grows as stages shrink
    always_comb begin
        half = 5'd1 << s;
        pos  = 5'(b) & (half - 5'd1);
        ia   = ((5'(b) >> s) << (s + 3'd1)) + pos;
        ib   = ia + half;
        k    = 4'(pos << (3'd4 - s));
    end

endmodule

// File: rtl/fft32_sequencer.sv
// Frame controller for the 32-point FFT: bit-reversed load, 80-cycle in-place
// DIT schedule against an external combinational butterfly, natural-order unload.
// Build option FFT32_STAGE_SCALE_EN: halve butterfly results every stage (1/32 overall).
module fft32_sequencer
    import fft32_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    fft32_sequencer_if.slave   bus,
    output logic               busy,
    output logic               done
);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, ocnt_q;
    logic [2:0] s_q;
    logic [3:0] b_q;
    logic [4:0] ia, ib;
    logic [3:0] k;
    cplx_t      mem [N_PTS];
    cplx_t      wr_a, wr_b;
    logic       load_fire, out_fire, last_bf;

    fft32_addr_gen u_addr_gen (
        .s  (s_q),
        .b  (b_q),
        .ia (ia),
        .ib (ib),
        .k  (k)
    );

    assign load_fire = bus.in_valid && (state_q == ST_LOAD);
    assign out_fire  = bus.out_ready && (state_q == ST_UNLOAD);
    assign last_bf   = (s_q == 3'(LOG2N - 1)) && (b_q == 4'd15);

`ifdef FFT32_STAGE_SCALE_EN
    assign wr_a = half_scale(bus.bf_a_f);
    assign wr_b = half_scale(bus.bf_b_f);
`else
    assign wr_a = bus.bf_a_f;
    assign wr_b = bus.bf_b_f;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_LOAD;
        else          state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:    if (load_fire && (cnt_q == 5'(N_PTS - 1))) state_d = ST_COMPUTE;
            ST_COMPUTE: if (last_bf)                               state_d = ST_UNLOAD;
            ST_UNLOAD:  if (out_fire && (ocnt_q == 5'(N_PTS - 1))) state_d = ST_LOAD;
            default:                                               state_d = ST_LOAD;
        endcase
    end

    // Stream and butterfly outputs decoded from state
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.bf_a_t    = '0;
        bus.bf_b_t    = '0;
        bus.bf_w      = TW_ROM[0];
        busy          = 1'b0;
        unique case (state_q)
            ST_LOAD: bus.in_ready = 1'b1;
            ST_COMPUTE: begin
                busy       = 1'b1;
                bus.bf_a_t = mem[ia];
                bus.bf_b_t = mem[ib];
                bus.bf_w   = TW_ROM[k];
            end
            ST_UNLOAD: begin
                bus.out_valid = 1'b1;
                bus.out_data  = mem[ocnt_q];
                bus.out_last  = (ocnt_q == 5'(N_PTS - 1));
            end
            default: ;
        endcase
    end

    // Load, butterfly and unload counters plus the end-of-compute pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            ocnt_q <= '0;
            s_q    <= '0;
            b_q    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_fire) cnt_q <= cnt_q + 5'd1;
            if (state_q == ST_COMPUTE) begin
                b_q  <= b_q + 4'd1;
                done <= last_bf;
                if (b_q == 4'd15) s_q <= last_bf ? 3'd0 : s_q + 3'd1;
            end
            if (out_fire) ocnt_q <= ocnt_q + 5'd1;
        end
    end

    // Sample store (bit-reversed) and in-place butterfly writeback; contents not reset
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[bitrev5(cnt_q)] <= bus.in_data;
        end else if (state_q == ST_COMPUTE) begin
            mem[ia] <= wr_a;
            mem[ib] <= wr_b;
        end
    end

endmodule

// File: tb/tb_fft32_sequencer.sv
// Directed bench for fft32_sequencer with a behavioural butterfly and address-generator unit test.
module tb_fft32_sequencer;
    import fft32_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic busy, done;

    always #5 clk = ~clk;

    fft32_sequencer_if bus ();

    fft32_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    logic [2:0] ag_s;
    logic [3:0] ag_b;
    logic [4:0] ag_ia, ag_ib;
    logic [3:0] ag_k;

    fft32_addr_gen u_ag (
        .s  (ag_s),
        .b  (ag_b),
        .ia (ag_ia),
        .ib (ag_ib),
        .k  (ag_k)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Butterfly: A' = A + W*B, B' = A - W*B, W carried with a gain of 1023
    function automatic int rdiv(input int p);
        if (p >= 0) return (p + 511) / 1023;
        return -((-p + 511) / 1023);
    endfunction

    int pr, pim, tr, ti;
    always_comb begin
        pr  = int'(bus.bf_w.re) * int'(bus.bf_b_t.re) - int'(bus.bf_w.im) * int'(bus.bf_b_t.im);
        pim = int'(bus.bf_w.re) * int'(bus.bf_b_t.im) + int'(bus.bf_w.im) * int'(bus.bf_b_t.re);
        tr  = rdiv(pr);
        ti  = rdiv(pim);
        bus.bf_a_f.re = 16'(int'(bus.bf_a_t.re) + tr);
        bus.bf_a_f.im = 16'(int'(bus.bf_a_t.im) + ti);
        bus.bf_b_f.re = 16'(int'(bus.bf_a_t.re) - tr);
        bus.bf_b_f.im = 16'(int'(bus.bf_a_t.im) - ti);
    end

    // Cycle counter and event monitors (sampled on the falling edge)
    int   cyc       = 0;
    int   busy_cnt  = 0;
    int   done_cnt  = 0;
    int   rdy_viol  = 0;
    int   ov_rise   = 0;
    logic ov_prev   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if ((busy || bus.out_valid) && bus.in_ready) rdy_viol <= rdy_viol + 1;
        if (bus.out_valid && !ov_prev) ov_rise <= cyc;
        ov_prev <= bus.out_valid;
    end

    task automatic send_frame(input logic [31:0] x [32], output int acc_cyc);
        int t;
        for (int i = 0; i < 32; i++) begin
            bus.in_data  = x[i];
            bus.in_valid = 1'b1;
            t = 0;
            while (!bus.in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                check_eq("in_ready_timeout", 32'(t), 32'd0);
                break;
            end
            @(negedge clk);
        end
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready one cycle in three
    task automatic recv_frame(input int mode, output logic [31:0] y [32]);
        int          n;
        int          t;
        logic        stalled;
        logic [31:0] hd;
        logic        hl;
        n = 0;
        t = 0;
        stalled = 1'b0;
        hd = '0;
        hl = 1'b0;
        for (int i = 0; i < 32; i++) y[i] = 'x;
        while (n < 32 && t < 3000) begin
            if (stalled) begin
                check_eq("stall_data", bus.out_data, hd);
                check_eq("stall_last", 32'(bus.out_last), 32'(hl));
            end
            bus.out_ready = (mode == 0) ? 1'b1 : ((t % 3) == 0);
            if (bus.out_valid && bus.out_ready) begin
                y[n] = bus.out_data;
                check_eq($sformatf("out_last_bin%0d", n), 32'(bus.out_last), 32'(n == 31));
                n++;
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                hd = bus.out_data;
                hl = bus.out_last;
            end
            @(negedge clk);
            t++;
        end
        if (n < 32) check_eq("recv_timeout", 32'(n), 32'd32);
        bus.out_ready = 1'b0;
    endtask

    // Hand-computed twiddles, entry k = W32^k * 1023
    logic [31:0] tw_exp [16] = '{
        32'h03FF_0000, 32'h03EB_FF38, 32'h03B1_FE79, 32'h0353_FDC8,
        32'h02D3_FD2D, 32'h0238_FCAD, 32'h0187_FC4F, 32'h00C8_FC15,
        32'h0000_FC01, 32'hFF38_FC15, 32'hFE79_FC4F, 32'hFDC8_FCAD,
        32'hFD2D_FD2D, 32'hFCAD_FDC8, 32'hFC4F_FE79, 32'hFC15_FF38
    };

    function automatic logic [31:0] neg_c(input logic [31:0] v);
        logic [15:0] r, i;
        r = v[31:16];
        i = v[15:0];
        return {16'(-r), 16'(-i)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] x [32];
        logic [31:0] y [32];
        logic [31:0] seen;
        logic [31:0] imp_exp, dc0_exp;
        int          acc, b0, d0, r0;

`ifdef FFT32_STAGE_SCALE_EN
        imp_exp = 32'h001F_0000;
        dc0_exp = 32'h0040_0000;
`else
        imp_exp = 32'h03FF_0000;
        dc0_exp = 32'h0800_0000;
`endif
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        ag_s = '0;
        ag_b = '0;

        // Address generator: full coverage per stage and hand points
        for (int s = 0; s < 5; s++) begin
            seen = '0;
            for (int b = 0; b < 16; b++) begin
                ag_s = 3'(s);
                ag_b = 4'(b);
                #1;
                seen[ag_ia] = 1'b1;
                seen[ag_ib] = 1'b1;
            end
            check_eq($sformatf("ag_cover_s%0d", s), seen, 32'hFFFF_FFFF);
        end
        ag_s = 3'd4; ag_b = 4'd5; #1;
        check_eq("ag_s4b5", {17'd0, ag_ia, ag_ib, ag_k}, {17'd0, 5'd5, 5'd21, 4'd5});
        ag_s = 3'd0; ag_b = 4'd3; #1;
        check_eq("ag_s0b3", {17'd0, ag_ia, ag_ib, ag_k}, {17'd0, 5'd6, 5'd7, 4'd0});
        ag_s = 3'd2; ag_b = 4'd6; #1;
        check_eq("ag_s2b6", {17'd0, ag_ia, ag_ib, ag_k}, {17'd0, 5'd10, 5'd14, 4'd8});
        ag_s = 3'd1; ag_b = 4'd7; #1;
        check_eq("ag_s1b7", {17'd0, ag_ia, ag_ib, ag_k}, {17'd0, 5'd13, 5'd15, 4'd8});

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_last",  32'(bus.out_last),  32'd0);
        check_eq("rst_busy",      32'(busy),          32'd0);
        check_eq("rst_done",      32'(done),          32'd0);
        check_eq("rst_bf_a_t",    bus.bf_a_t,         32'd0);
        check_eq("rst_bf_b_t",    bus.bf_b_t,         32'd0);
        check_eq("rst_bf_w",      bus.bf_w,           32'h03FF_0000);
        reset_n = 1'b1;
        @(negedge clk);

        // Impulse with continuous handshakes: flat spectrum and latency
        for (int i = 0; i < 32; i++) x[i] = '0;
        x[0] = 32'h03FF_0000;
        b0 = busy_cnt; d0 = done_cnt; r0 = rdy_viol;
        send_frame(x, acc);
        recv_frame(0, y);
        for (int i = 0; i < 32; i++) check_eq($sformatf("imp_bin%0d", i), y[i], imp_exp);
        check_eq("busy_cycles",   32'(busy_cnt - b0), 32'd80);
        check_eq("done_pulses",   32'(done_cnt - d0), 32'd1);
        check_eq("first_valid",   32'(ov_rise - acc), 32'd80);
        check_eq("ready_in_busy", 32'(rdy_viol - r0), 32'd0);
        check_eq("ready_back",    32'(bus.in_ready),  32'd1);

        // DC with 1-in-3 backpressure
        for (int i = 0; i < 32; i++) x[i] = 32'h0040_0000;
        r0 = rdy_viol;
        send_frame(x, acc);
        recv_frame(1, y);
        check_eq("dc_bin0", y[0], dc0_exp);
        for (int i = 1; i < 32; i++) check_eq($sformatf("dc_bin%0d", i), y[i], 32'd0);
        check_eq("dc_ready_in_busy", 32'(rdy_viol - r0), 32'd0);
        check_eq("dc_ready_back",    32'(bus.in_ready),  32'd1);

`ifndef FFT32_STAGE_SCALE_EN
        // Delayed impulse x[1]: bins are the twiddles, negated in the upper half
        for (int i = 0; i < 32; i++) x[i] = '0;
        x[1] = 32'h03FF_0000;
        send_frame(x, acc);
        repeat (69) @(negedge clk);
        check_eq("s4b5_bf_w",   bus.bf_w,   32'h0238_FCAD);
        check_eq("s4b5_bf_a_t", bus.bf_a_t, 32'h0000_0000);
        check_eq("s4b5_bf_b_t", bus.bf_b_t, 32'h03FF_0000);
        recv_frame(0, y);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("tone_bin%0d", i), y[i], tw_exp[i]);
            check_eq($sformatf("tone_bin%0d", i + 16), y[i + 16], neg_c(tw_exp[i]));
        end
`endif

        // Reset during stage 2 aborts the frame without a done pulse
        for (int i = 0; i < 32; i++) x[i] = 32'(i) * 32'h0001_0001;
        send_frame(x, acc);
        repeat (36) @(negedge clk);
        check_eq("pre_abort_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_busy",      32'(busy),          32'd0);
        check_eq("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_done",      32'(done),          32'd0);
        check_eq("abort_bf_a_t",    bus.bf_a_t,         32'd0);
        check_eq("abort_bf_w",      bus.bf_w,           32'h03FF_0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("abort_no_done",  32'(done_cnt - d0), 32'd0);
        check_eq("abort_in_ready2", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 32; i++) x[i] = '0;
        x[0] = 32'h03FF_0000;
        send_frame(x, acc);
        recv_frame(0, y);
        for (int i = 0; i < 32; i++) check_eq($sformatf("post_abort_bin%0d", i), y[i], imp_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
